// File: rtl/rr_issue_pkg.sv
// Shared constants, FSM encoding and decode helper for the R-type issue block
// and the ALUs it feeds.
package rr_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  // The alternate funct7 encoding only exists for SUB and SRA.
  function automatic logic is_legal(input logic [31:0] ins, input logic [6:0] opc);
    logic ok;
    if (ins[6:0] != opc) begin
      ok = 1'b0;
    end else if (ins[31:25] == F7_BASE) begin
      ok = 1'b1;
    end else if (ins[31:25] == F7_ALT) begin
      ok = (ins[14:12] == F3_ADD_SUB) || (ins[14:12] == F3_SRL_SRA);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/rr_issue_if.sv
// Instruction handshake, ALU drive and retire signals of rr_issue.
interface rr_issue_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        alu_base_enable;
  logic        alu_extra_enable;
  logic [2:0]  funct3;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [31:0] rd_result;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic        illegal;

  modport master (
    output instr_valid, instruction, rd_result,
    input  instr_ready, alu_base_enable, alu_extra_enable, funct3,
           rs1_value, rs2_value, retire_valid, retire_rd, illegal
  );

  modport slave (
    input  instr_valid, instruction, rd_result,
    output instr_ready, alu_base_enable, alu_extra_enable, funct3,
           rs1_value, rs2_value, retire_valid, retire_rd, illegal
  );

endinterface

// File: rtl/rr_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, asynchronous clear.
module rr_regfile
  import rr_issue_pkg::*;
#(
  parameter int REG_COUNT = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [REG_COUNT-1:0][31:0] r_mem;

  // Storage; entry 0 is never written so it stays at its cleared value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem <= {REG_COUNT{32'd0}};
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];

endmodule

// File: rtl/rr_issue.sv
// Three-state issue engine for RV32I R-type ops: decode, drive one of two
// external ALUs for a cycle, then write back the shared result bus.
module rr_issue
  import rr_issue_pkg::*;
#(
  parameter logic [6:0] OPCODE_OP = OPC_OP,
  parameter int         REG_COUNT = 32
) (
  input logic       clock,
  input logic       reset_n,
  rr_issue_if.slave bus
);

  state_t      r_state;
  state_t      w_next_state;
  logic        w_legal;
  logic        w_we;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;

  logic        r_ready;
  logic        r_base_en;
  logic        r_extra_en;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_result;
  logic        r_retire_valid;
  logic [4:0]  r_retire_rd;
  logic        r_illegal;

  assign w_legal = is_legal(bus.instruction, OPCODE_OP);
  assign w_we    = (r_state == WB);

  rr_regfile #(
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_we     (w_we),
    .i_waddr  (r_rd),
    .i_wdata  (r_result),
    .i_raddr1 (bus.instruction[19:15]),
    .i_raddr2 (bus.instruction[24:20]),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state; illegal words are consumed without leaving IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.instr_valid && w_legal) begin
          w_next_state = ISSUE;
        end else begin
          w_next_state = IDLE;
        end
      end
      ISSUE:   w_next_state = WB;
      WB:      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs; result is taken off the bus as ISSUE ends
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ready        <= 1'b1;
      r_base_en      <= 1'b0;
      r_extra_en     <= 1'b0;
      r_rd           <= 5'd0;
      r_funct3       <= 3'd0;
      r_rs1          <= 32'd0;
      r_rs2          <= 32'd0;
      r_result       <= 32'd0;
      r_retire_valid <= 1'b0;
      r_retire_rd    <= 5'd0;
      r_illegal      <= 1'b0;
    end else begin
      r_ready        <= (w_next_state == IDLE);
      r_retire_valid <= 1'b0;
      r_illegal      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.instr_valid) begin
            r_rd     <= bus.instruction[11:7];
            r_funct3 <= bus.instruction[14:12];
            r_rs1    <= w_rs1_data;
            r_rs2    <= w_rs2_data;
            if (w_legal) begin
              r_base_en  <= ~bus.instruction[30];
              r_extra_en <= bus.instruction[30];
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        ISSUE: begin
          r_base_en  <= 1'b0;
          r_extra_en <= 1'b0;
          r_result   <= bus.rd_result;
        end
        WB: begin
          r_retire_valid <= 1'b1;
          r_retire_rd    <= r_rd;
        end
        default: begin
          r_base_en  <= 1'b0;
          r_extra_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready      = r_ready;
  assign bus.alu_base_enable  = r_base_en;
  assign bus.alu_extra_enable = r_extra_en;
  assign bus.funct3           = r_funct3;
  assign bus.rs1_value        = r_rs1;
  assign bus.rs2_value        = r_rs2;
  assign bus.retire_valid     = r_retire_valid;
  assign bus.retire_rd        = r_retire_rd;
  assign bus.illegal          = r_illegal;

endmodule

// File: tb/tb_rr_issue.sv
// Self-checking bench for rr_issue: table of instructions with expected
// register contents, queue scoreboard for issue/retire/illegal events.
module tb_rr_issue;

  localparam logic [6:0] F7B = 7'b0000000;
  localparam logic [6:0] F7A = 7'b0100000;

  typedef struct {
    logic [31:0] ins;
    bit          fen;
    logic [31:0] fval;
    bit          legal;
    bit          alt;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    bit          alt;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ref_rf [32];
  iss_t        iss_q [$];
  logic [4:0]  ret_q [$];
  int          ill_pending = 0;
  bit          prev_en = 1'b0;

  bit          alu_force_en = 1'b0;
  logic [31:0] alu_force_val = 32'd0;
  logic [31:0] alu_out;

  rr_issue_if bus();

  rr_issue dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // ALU pair; idle bus modelled as a poison value, forced value used to seed registers
  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    if (bus.alu_base_enable) begin
      if (alu_force_en) begin
        alu_out = alu_force_val;
      end else begin
        case (bus.funct3)
          3'b000:  alu_out = bus.rs1_value + bus.rs2_value;
          3'b001:  alu_out = bus.rs1_value << bus.rs2_value[4:0];
          3'b010:  alu_out = {31'd0, $signed(bus.rs1_value) < $signed(bus.rs2_value)};
          3'b011:  alu_out = {31'd0, bus.rs1_value < bus.rs2_value};
          3'b100:  alu_out = bus.rs1_value ^ bus.rs2_value;
          3'b101:  alu_out = bus.rs1_value >> bus.rs2_value[4:0];
          3'b110:  alu_out = bus.rs1_value | bus.rs2_value;
          default: alu_out = bus.rs1_value & bus.rs2_value;
        endcase
      end
    end else if (bus.alu_extra_enable) begin
      if (bus.funct3 == 3'b101) alu_out = $signed(bus.rs1_value) >>> bus.rs2_value[4:0];
      else                      alu_out = bus.rs1_value - bus.rs2_value;
    end
  end
  assign bus.rd_result = alu_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input bit fen, input logic [31:0] fval,
                              input bit legal, input bit alt, input logic [31:0] res);
    vec_t v;
    v.ins = ins; v.fen = fen; v.fval = fval; v.legal = legal; v.alt = alt; v.res = res;
    return v;
  endfunction

  // Scoreboard monitor: pops expected events as the DUT produces them
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_en <= 1'b0;
    end else begin
      if (bus.alu_base_enable && bus.alu_extra_enable) chk("both_enables", 32'd1, 32'd0);
      if (prev_en) chk("wb_enables_low", {31'd0, bus.alu_base_enable | bus.alu_extra_enable}, 32'd0);
      if (bus.alu_base_enable || bus.alu_extra_enable) begin
        if (iss_q.size() == 0) begin
          chk("issue_expected", 32'd0, 32'd1);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          chk("extra_enable", {31'd0, bus.alu_extra_enable}, {31'd0, e.alt});
          chk("funct3", {29'd0, bus.funct3}, {29'd0, e.f3});
          chk("rs1_value", bus.rs1_value, e.a);
          chk("rs2_value", bus.rs2_value, e.b);
        end
      end
      prev_en <= bus.alu_base_enable | bus.alu_extra_enable;
      if (bus.retire_valid) begin
        if (ret_q.size() == 0) chk("retire_expected", 32'd0, 32'd1);
        else                   chk("retire_rd", {27'd0, bus.retire_rd}, {27'd0, ret_q.pop_front()});
      end
      if (bus.illegal) begin
        chk("illegal_expected", {31'd0, ill_pending > 0}, 32'd1);
        chk("illegal_ready", {31'd0, bus.instr_ready}, 32'd1);
        if (ill_pending > 0) ill_pending--;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_before_accept", {31'd0, bus.instr_ready}, 32'd1);
  endtask

  task automatic expect_accept(input logic [31:0] ins, input bit legal, input logic [31:0] res);
    iss_t e;
    logic [4:0] rd;
    rd = ins[11:7];
    if (legal) begin
      e.alt = ins[30]; e.f3 = ins[14:12];
      e.a = ref_rf[ins[19:15]]; e.b = ref_rf[ins[24:20]];
      iss_q.push_back(e);
      ret_q.push_back(rd);
      if (rd != 5'd0) ref_rf[rd] = res;
    end else begin
      ill_pending++;
    end
  endtask

  task automatic send(input vec_t v);
    wait_ready();
    alu_force_en = v.fen;
    alu_force_val = v.fval;
    expect_accept(v.ins, v.legal, v.res);
    bus.instr_valid = 1'b1;
    bus.instruction = v.ins;
    @(posedge clock);
    #1;
    bus.instr_valid = 1'b0;
    bus.instruction = 32'd0;
    @(negedge clock);
    chk("ready_after_accept", {31'd0, bus.instr_ready}, {31'd0, !v.legal});
  endtask

  vec_t vecs [$];
  int   acc_cnt;
  int   last_acc;

  initial begin
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    bus.instr_valid = 1'b0;
    bus.instruction = 32'd0;

    // Reset values
    #12;
    chk("rst_base_en", {31'd0, bus.alu_base_enable}, 32'd0);
    chk("rst_extra_en", {31'd0, bus.alu_extra_enable}, 32'd0);
    chk("rst_funct3", {29'd0, bus.funct3}, 32'd0);
    chk("rst_rs1", bus.rs1_value, 32'd0);
    chk("rst_rs2", bus.rs2_value, 32'd0);
    chk("rst_retire_valid", {31'd0, bus.retire_valid}, 32'd0);
    chk("rst_retire_rd", {27'd0, bus.retire_rd}, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", {31'd0, bus.instr_ready}, 32'd1);

    vecs.push_back(mk(rt(F7B, 5'd0, 5'd0, 3'b000, 5'd1), 1'b1, 32'd7, 1'b1, 1'b0, 32'd7));
    vecs.push_back(mk(rt(F7B, 5'd0, 5'd0, 3'b000, 5'd2), 1'b1, 32'd5, 1'b1, 1'b0, 32'd5));
    vecs.push_back(mk(rt(F7A, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 32'd0, 1'b1, 1'b1, 32'd2));
    vecs.push_back(mk(rt(F7B, 5'd0, 5'd0, 3'b000, 5'd4), 1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000));
    vecs.push_back(mk(rt(F7B, 5'd0, 5'd0, 3'b000, 5'd5), 1'b1, 32'd4, 1'b1, 1'b0, 32'd4));
    vecs.push_back(mk(rt(F7A, 5'd5, 5'd4, 3'b101, 5'd6), 1'b0, 32'd0, 1'b1, 1'b1, 32'hF800_0000));
    vecs.push_back(mk(rt(F7B, 5'd5, 5'd4, 3'b101, 5'd8), 1'b0, 32'd0, 1'b1, 1'b0, 32'h0800_0000));
    vecs.push_back(mk(rt(F7B, 5'd2, 5'd1, 3'b100, 5'd9), 1'b0, 32'd0, 1'b1, 1'b0, 32'd2));
    vecs.push_back(mk(rt(F7B, 5'd3, 5'd6, 3'b000, 5'd10), 1'b0, 32'd0, 1'b1, 1'b0, 32'hF800_0002));
    vecs.push_back(mk(rt(F7A, 5'd2, 5'd1, 3'b001, 5'd11), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0));
    vecs.push_back(mk({F7B, 5'd2, 5'd1, 3'b000, 5'd12, 7'b0010011}, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0));
    vecs.push_back(mk(rt(F7A, 5'd2, 5'd1, 3'b000, 5'd0), 1'b0, 32'd0, 1'b1, 1'b1, 32'd0));
    vecs.push_back(mk(rt(F7B, 5'd3, 5'd0, 3'b000, 5'd13), 1'b0, 32'd0, 1'b1, 1'b0, 32'd2));
    vecs.push_back(mk(rt(F7B, 5'd1, 5'd2, 3'b011, 5'd14), 1'b0, 32'd0, 1'b1, 1'b0, 32'd1));
    vecs.push_back(mk(rt(F7B, 5'd1, 5'd6, 3'b010, 5'd15), 1'b0, 32'd0, 1'b1, 1'b0, 32'd1));
    vecs.push_back(mk(rt(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd16), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0));
    vecs.push_back(mk(rt(F7B, 5'd12, 5'd11, 3'b000, 5'd17), 1'b0, 32'd0, 1'b1, 1'b0, 32'd0));
    vecs.push_back(mk(rt(F7B, 5'd2, 5'd6, 3'b110, 5'd18), 1'b0, 32'd0, 1'b1, 1'b0, 32'hF800_0005));
    vecs.push_back(mk(rt(F7B, 5'd5, 5'd1, 3'b001, 5'd19), 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0070));
    vecs.push_back(mk(rt(F7B, 5'd1, 5'd10, 3'b111, 5'd20), 1'b0, 32'd0, 1'b1, 1'b0, 32'd2));
    vecs.push_back(mk(rt(F7B, 5'd6, 5'd3, 3'b000, 5'd0), 1'b0, 32'd0, 1'b1, 1'b0, 32'd0));
    vecs.push_back(mk(rt(F7B, 5'd9, 5'd8, 3'b000, 5'd0), 1'b0, 32'd0, 1'b1, 1'b0, 32'd0));
    vecs.push_back(mk(rt(F7B, 5'd13, 5'd10, 3'b000, 5'd0), 1'b0, 32'd0, 1'b1, 1'b0, 32'd0));
    vecs.push_back(mk(rt(F7B, 5'd15, 5'd14, 3'b000, 5'd0), 1'b0, 32'd0, 1'b1, 1'b0, 32'd0));
    vecs.push_back(mk(rt(F7B, 5'd19, 5'd18, 3'b000, 5'd0), 1'b0, 32'd0, 1'b1, 1'b0, 32'd0));
    vecs.push_back(mk(rt(F7B, 5'd17, 5'd20, 3'b000, 5'd0), 1'b0, 32'd0, 1'b1, 1'b0, 32'd0));

    foreach (vecs[i]) send(vecs[i]);

    // instr_valid held high: one accept every third cycle
    wait_ready();
    alu_force_en = 1'b0;
    bus.instruction = rt(F7B, 5'd2, 5'd1, 3'b000, 5'd21);
    bus.instr_valid = 1'b1;
    acc_cnt = 0;
    last_acc = -3;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clock);
      if (bus.instr_ready) begin
        chk("stream_gap", c - last_acc, 32'd3);
        last_acc = c;
        acc_cnt++;
        expect_accept(bus.instruction, 1'b1, 32'd12);
      end
    end
    @(negedge clock);
    bus.instr_valid = 1'b0;
    chk("stream_accepts", acc_cnt, 32'd4);
    wait_ready();

    // Reset during ISSUE of SUB x7 aborts it
    expect_accept(rt(F7A, 5'd2, 5'd1, 3'b000, 5'd7), 1'b1, 32'd2);
    bus.instruction = rt(F7A, 5'd2, 5'd1, 3'b000, 5'd7);
    bus.instr_valid = 1'b1;
    @(posedge clock);
    #1 bus.instr_valid = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    void'(ret_q.pop_back());
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    @(negedge clock);
    chk("abort_enables", {30'd0, bus.alu_base_enable, bus.alu_extra_enable}, 32'd0);
    chk("abort_retire", {31'd0, bus.retire_valid}, 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("abort_idle_ready", {31'd0, bus.instr_ready}, 32'd1);
    repeat (4) @(negedge clock);
    send(mk(rt(F7B, 5'd1, 5'd7, 3'b000, 5'd0), 1'b0, 32'd0, 1'b1, 1'b0, 32'd0));
    wait_ready();
    repeat (2) @(negedge clock);

    chk("issue_queue_drained", iss_q.size(), 32'd0);
    chk("retire_queue_drained", ret_q.size(), 32'd0);
    chk("illegal_drained", ill_pending, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rr_issue.md
RR_ISSUE -- requirements
Module: rr_issue

Interface
REQ-001 The module SHALL have parameter OPCODE_OP, default 7'b0110011, the R-type opcode accepted for issue.
REQ-002 The module SHALL have parameter REG_COUNT, default 32, the number of architectural registers; the value is fixed at 32.
REQ-003 The module SHALL have the port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have the port reset_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 The module SHALL have the port instr_valid, input, 1 bit, meaning the instruction word is presented.
REQ-006 The module SHALL have the port instr_ready, output, 1 bit, meaning the module can accept an instruction.
REQ-007 The module SHALL have the port instruction, input, 32 bits, the RV32I instruction word.
REQ-008 The module SHALL have the port alu_base_enable, output, 1 bit, the enable for the funct7=0000000 ALU.
REQ-009 The module SHALL have the port alu_extra_enable, output, 1 bit, the enable for the funct7=0100000 ALU (SUB/SRA).
REQ-010 The module SHALL have the port funct3, output, 3 bits, the operation select driven to both ALUs.
REQ-011 The module SHALL have the ports rs1_value and rs2_value, output, 32 bits each, the operands driven to both ALUs.
REQ-012 The module SHALL have the port rd_result, input, 32 bits, the shared ALU result bus; it is high-Z when no ALU is enabled.
REQ-013 The module SHALL have the port retire_valid, output, 1 bit, a one-cycle pulse per completed instruction.
REQ-014 The module SHALL have the port retire_rd, output, 5 bits, the destination index of the retired instruction.
REQ-015 The module SHALL have the port illegal, output, 1 bit, a one-cycle pulse on a rejected instruction.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and WB.
REQ-017 instr_ready SHALL be 1 only in IDLE.
REQ-018 An accept SHALL occur at an edge in IDLE when instr_valid=1; at that edge the module latches rd, funct3 and funct7 and reads regfile[rs1] and regfile[rs2] into the operand registers.
REQ-019 A legal instruction SHALL have opcode=OPCODE_OP and either funct7=0000000 (any funct3) or funct7=0100000 with funct3 in {000, 101}.
REQ-020 On a legal accept the FSM SHALL move IDLE->ISSUE.
REQ-021 On an illegal accept the FSM SHALL stay in IDLE, illegal SHALL be 1 for the next cycle, and no enable or register write SHALL occur.
REQ-022 In ISSUE exactly one enable SHALL be 1, selected by funct7 bit 30; funct3, rs1_value and rs2_value SHALL be stable; ISSUE SHALL always move to WB after one cycle.
REQ-023 In WB both enables SHALL be 0.
REQ-024 At the edge ending WB the module SHALL write regfile[rd] with the rd_result value captured at the WB-entry edge (the ALU updates at the edge ending ISSUE), unless rd=0.
REQ-025 At the edge ending WB the module SHALL set retire_valid=1 and retire_rd=rd for one cycle and return to IDLE.
REQ-026 Latency SHALL be 3 cycles from accept to next instr_ready; throughput SHALL be one instruction per 3 cycles.
REQ-027 x0 SHALL always read as 0; writes with rd=0 SHALL be discarded, but retire SHALL still pulse.
REQ-028 A read of the register written in the previous WB SHALL see the new value; no bypass is needed because the write precedes the next accept.
REQ-029 Arithmetic SHALL be performed entirely in the ALUs; this block SHALL not modify the 32-bit result.
REQ-030 The two enables SHALL never be 1 simultaneously in any state.
REQ-031 instr_valid SHALL be ignored outside IDLE.

Reset
REQ-032 While reset_n=0: state=IDLE, all 32 registers=0, both enables=0, funct3=0, rs1_value=0, rs2_value=0, retire_valid=0, retire_rd=0, illegal=0; instr_ready=1 after release.
REQ-033 Assertion of reset_n in ISSUE or WB SHALL abort the instruction: no regfile write and no retire pulse.

Structure
REQ-034 Opcode, funct7 and funct3 constants and the FSM state encoding SHALL live in a shared package used by the ALU blocks.
REQ-035 The register file SHALL be one sub-module, rr_regfile: 2 asynchronous read ports, 1 synchronous write port, x0 hardwired to 0, async active-low clear.

Verification
REQ-036 Write x1=7, x2=5 via ADD from x0 (base ALU model), then SUB x3,x1,x2 -> alu_extra_enable high one cycle, funct3=000, x3=2, retire_rd=3.
REQ-037 x4=32'h80000000, x5=4, SRA x6,x4,x5 -> x6=32'hF8000000.
REQ-038 funct7=0100000 with funct3=001 -> illegal pulse, no enable, instr_ready stays 1, no register changes.
REQ-039 SUB x0,x1,x2 -> retire pulses with retire_rd=0 and x0 still reads 0.
REQ-040 reset_n low during ISSUE of SUB x7 -> x7 remains 0, no retire, IDLE after release.
REQ-041 instr_valid held high continuously -> accepts exactly every 3rd cycle, with the enables never both high.
